uvmt_cv32e40x_obi_pma_responder: RTL



---
 rtl/uvmt_cv32e40x_obi_pma_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uvmt_cv32e40x_obi_pma_responder.sv
// OBI data-side responder used by the CV32E40X testbench.
// Accepts requests into a small in-order FIFO and returns each response
// after a fixed latency. Flags accepted requests whose memtype disagrees
// with the PMA region map. Read data is the inverted address so the
// bench can recognise which request a response belongs to.

package uvmt_cv32e40x_obi_pma_pkg;

  typedef struct packed {
    logic [31:0] word_addr_low;
    logic [31:0] word_addr_high;
    logic        main;
    logic        bufferable;
    logic        cacheable;
  } pma_cfg_t;

endpackage

module uvmt_cv32e40x_obi_pma_responder
  import uvmt_cv32e40x_obi_pma_pkg::*;
#(
  parameter int                              PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t [PMA_NUM_REGIONS-1:0]  PMA_CFG         = '0,
  parameter int                              RESP_LATENCY    = 2,
  parameter int                              FIFO_DEPTH      = 2,
  parameter logic [31:0]                     ERR_ADDR_LOW    = 32'hFFFF_FFF0,
  parameter logic [31:0]                     ERR_ADDR_HIGH   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  memtype_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        memtype_mismatch_o,
  output logic [3:0]  outstanding_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [31:0]      fifo_addr [FIFO_DEPTH];
  logic             fifo_we   [FIFO_DEPTH];
  logic             fifo_err  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       count;

  logic [3:0]       head_cnt;
  logic             head_loaded;

  logic             push;
  logic             pop;
  logic             load_head;
  logic             err_hit;
  logic             exp_buf;
  logic             exp_cach;
  logic             region_hit;
  logic [33:0]      addr_ext;

  // Write data and byte enables are deliberately not stored.
  logic             unused_wr;
  assign unused_wr = ^{be_i, wdata_i};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant only on spare room as of the start of the cycle; a same-cycle pop
  // does not free a slot for the incoming request.
  assign gnt_o = req_i && (count < 4'(FIFO_DEPTH));
  assign push  = req_i && gnt_o;

  assign rvalid_o      = (count != 4'd0) && head_loaded && (head_cnt == 4'd0);
  assign pop           = rvalid_o;
  assign outstanding_o = count;

  // Response payload only while rvalid_o is high; writes return zero data.
  assign err_o   = rvalid_o ? fifo_err[rd_ptr] : 1'b0;
  assign rdata_o = (rvalid_o && !fifo_we[rd_ptr]) ? ~fifo_addr[rd_ptr] : 32'h0;

  assign err_hit = ({1'b0, addr_i} >= {1'b0, ERR_ADDR_LOW}) &&
                   ({1'b0, addr_i} <= {1'b0, ERR_ADDR_HIGH});

  // A new head appears after a push into an empty FIFO, or after a pop that
  // leaves something behind (including an entry pushed in the same cycle).
  assign load_head = (push && (count == 4'd0)) ||
                     (pop && ((count > 4'd1) || push));

  assign addr_ext = {2'b00, addr_i};

  // First matching region wins; unmatched addresses expect non-bufferable,
  // non-cacheable. Reads can never be bufferable.
  always_comb begin
    region_hit = 1'b0;
    exp_buf    = 1'b0;
    exp_cach   = 1'b0;
    for (int i = 0; i < PMA_NUM_REGIONS; i++) begin
      if (!region_hit &&
          (addr_ext >= {PMA_CFG[i].word_addr_low, 2'b00}) &&
          (addr_ext <  {PMA_CFG[i].word_addr_high, 2'b00})) begin
        region_hit = 1'b1;
        exp_buf    = PMA_CFG[i].bufferable;
        exp_cach   = PMA_CFG[i].cacheable;
      end
    end
    exp_buf = exp_buf & we_i;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= 32'h0;
        fifo_we[i]   <= 1'b0;
        fifo_err[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= addr_i;
        fifo_we[wr_ptr]   <= we_i;
        fifo_err[wr_ptr]  <= err_hit;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Head latency counter: loads on a new head, counts down and holds at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_loaded <= 1'b0;
      head_cnt    <= 4'd0;
    end else if (load_head) begin
      head_loaded <= 1'b1;
      head_cnt    <= 4'(RESP_LATENCY - 1);
    end else if (pop) begin
      head_loaded <= 1'b0;
    end else if (head_loaded && (head_cnt != 4'd0)) begin
      head_cnt <= head_cnt - 4'd1;
    end
  end

  // One-cycle flag for an accepted request with unexpected memory attributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memtype_mismatch_o <= 1'b0;
    end else begin
      memtype_mismatch_o <= push && (memtype_i != {exp_cach, exp_buf});
    end
  end

endmodule
